ps2_key_decoder: RTL and testbench

Consumes raw PS/2 scan-code set 2 bytes from the PS/2 receiver stage and turns them into ASCII key events queued for the CPU. Tracks the E0/F0 prefix sequence, the shift/ctrl/caps-lock modifier state, and discards break and unmapped codes. Mapped make codes are pushed into a show-ahead FIFO that the CPU's I/O register logic pops one key at a time.

---
 rtl/ps2_key_if.sv | 29 ++
 rtl/ps2_key_decoder.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_ps2_key_decoder.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_if.sv
// CPU-side key FIFO port bundle for the PS/2 key decoder.
// master = decoder, slave = CPU I/O register logic.
interface ps2_key_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    key_data;
  logic          key_valid;
  logic          key_rd;
  logic [CW-1:0] key_count;
  logic          overflow;

  modport master (
    output key_data,
    output key_valid,
    output key_count,
    output overflow,
    input  key_rd
  );

  modport slave (
    input  key_data,
    input  key_valid,
    input  key_count,
    input  overflow,
    output key_rd
  );
endinterface

// File: rtl/ps2_key_decoder.sv
// PS/2 set-2 scan code to ASCII decoder with prefix FSM,
// modifier tracking and a show-ahead key FIFO.
module ps2_key_decoder #(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] scan_code,
  input  logic       scan_strobe,
  ps2_key_if.master  kif
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    EXT,
    BRK,
    EXT_BRK
  } state_t;

  function automatic logic [4:0] letter_idx(
    input logic [7:0] c
  );
    case (c)
      8'h1C:   return 5'd1;
      8'h32:   return 5'd2;
      8'h21:   return 5'd3;
      8'h23:   return 5'd4;
      8'h24:   return 5'd5;
      8'h2B:   return 5'd6;
      8'h34:   return 5'd7;
      8'h33:   return 5'd8;
      8'h43:   return 5'd9;
      8'h3B:   return 5'd10;
      8'h42:   return 5'd11;
      8'h4B:   return 5'd12;
      8'h3A:   return 5'd13;
      8'h31:   return 5'd14;
      8'h44:   return 5'd15;
      8'h4D:   return 5'd16;
      8'h15:   return 5'd17;
      8'h2D:   return 5'd18;
      8'h1B:   return 5'd19;
      8'h2C:   return 5'd20;
      8'h3C:   return 5'd21;
      8'h2A:   return 5'd22;
      8'h1D:   return 5'd23;
      8'h22:   return 5'd24;
      8'h35:   return 5'd25;
      8'h1A:   return 5'd26;
      default: return 5'd0;
    endcase
  endfunction

  // {hit, ascii}; shifted digits follow the US layout
  function automatic logic [8:0] digit_code(
    input logic [7:0] c,
    input logic       sh
  );
    case (c)
      8'h45:   return sh ? 9'h129 : 9'h130;
      8'h16:   return sh ? 9'h121 : 9'h131;
      8'h1E:   return sh ? 9'h140 : 9'h132;
      8'h26:   return sh ? 9'h123 : 9'h133;
      8'h25:   return sh ? 9'h124 : 9'h134;
      8'h2E:   return sh ? 9'h125 : 9'h135;
      8'h36:   return sh ? 9'h15E : 9'h136;
      8'h3D:   return sh ? 9'h126 : 9'h137;
      8'h3E:   return sh ? 9'h12A : 9'h138;
      8'h46:   return sh ? 9'h128 : 9'h139;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] other_code(
    input logic [7:0] c
  );
    case (c)
      8'h29:   return 9'h120;
      8'h5A:   return 9'h10D;
      8'h66:   return 9'h108;
      8'h0D:   return 9'h109;
      8'h76:   return 9'h11B;
      default: return 9'h000;
    endcase
  endfunction

  function automatic logic [8:0] ext_code(
    input logic [7:0] c
  );
    case (c)
      8'h75:   return 9'h180;
      8'h72:   return 9'h181;
      8'h6B:   return 9'h182;
      8'h74:   return 9'h183;
      default: return 9'h000;
    endcase
  endfunction

  // sync flops reset high so a strobe held across reset is not an edge
  logic sync1, sync2, sync_hist;
  logic byte_ev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1     <= 1'b1;
      sync2     <= 1'b1;
      sync_hist <= 1'b1;
    end else begin
      sync1     <= scan_strobe;
      sync2     <= sync1;
      sync_hist <= sync2;
    end
  end

  assign byte_ev = sync2 & ~sync_hist;

  state_t state, state_n;
  logic   shift_l, shift_r, ctrl_l, ctrl_r, caps;
  logic   shift_l_n, shift_r_n, ctrl_l_n, ctrl_r_n, caps_n;
  logic   push;
  logic [7:0] push_data;

  logic       is_make, is_brk, is_ext;
  logic [4:0] lidx;
  logic [8:0] dig, oth, ext;
  logic       shift, ctrl, upper;

  assign shift = shift_l | shift_r;
  assign ctrl  = ctrl_l | ctrl_r;
  assign upper = shift ^ caps;
  assign lidx  = letter_idx(scan_code);
  assign dig   = digit_code(scan_code, shift);
  assign oth   = other_code(scan_code);
  assign ext   = ext_code(scan_code);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      shift_l <= 1'b0;
      shift_r <= 1'b0;
      ctrl_l  <= 1'b0;
      ctrl_r  <= 1'b0;
      caps    <= 1'b0;
    end else begin
      state   <= state_n;
      shift_l <= shift_l_n;
      shift_r <= shift_r_n;
      ctrl_l  <= ctrl_l_n;
      ctrl_r  <= ctrl_r_n;
      caps    <= caps_n;
    end
  end

  always_comb begin
    state_n   = state;
    shift_l_n = shift_l;
    shift_r_n = shift_r;
    ctrl_l_n  = ctrl_l;
    ctrl_r_n  = ctrl_r;
    caps_n    = caps;
    push      = 1'b0;
    push_data = 8'h00;
    is_make   = 1'b0;
    is_brk    = 1'b0;
    is_ext    = 1'b0;

    if (byte_ev) begin
      unique case (state)
        IDLE: begin
          if (scan_code == 8'hE0) state_n = EXT;
          else if (scan_code == 8'hF0) state_n = BRK;
          else is_make = 1'b1;
        end
        EXT: begin
          if (scan_code == 8'hE0) state_n = EXT;
          else if (scan_code == 8'hF0) state_n = EXT_BRK;
          else begin
            is_make = 1'b1;
            is_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        BRK: begin
          if (scan_code != 8'hF0) begin
            is_brk  = 1'b1;
            state_n = IDLE;
          end
        end
        EXT_BRK: begin
          if (scan_code != 8'hF0) begin
            is_brk  = 1'b1;
            is_ext  = 1'b1;
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end

    if (is_make && !is_ext) begin
      unique case (1'b1)
        scan_code == 8'h12: shift_l_n = 1'b1;
        scan_code == 8'h59: shift_r_n = 1'b1;
        scan_code == 8'h14: ctrl_l_n  = 1'b1;
        scan_code == 8'h58: caps_n    = ~caps;
        lidx != 5'd0: begin
          push = 1'b1;
          if (ctrl) push_data = {3'b000, lidx};
          else if (upper) push_data = {3'b010, lidx};
          else push_data = {3'b011, lidx};
        end
        dig[8]: begin
          push      = 1'b1;
          push_data = dig[7:0];
        end
        oth[8]: begin
          push      = 1'b1;
          push_data = oth[7:0];
        end
        default: ;
      endcase
    end

    if (is_make && is_ext) begin
      if (scan_code == 8'h14) ctrl_r_n = 1'b1;
      else if (ext[8]) begin
        push      = 1'b1;
        push_data = ext[7:0];
      end
    end

    if (is_brk && !is_ext) begin
      if (scan_code == 8'h12) shift_l_n = 1'b0;
      if (scan_code == 8'h59) shift_r_n = 1'b0;
      if (scan_code == 8'h14) ctrl_l_n  = 1'b0;
    end

    if (is_brk && is_ext && scan_code == 8'h14) ctrl_r_n = 1'b0;
  end

  logic [7:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic        ovf;
  logic        empty, full, do_pop, do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL_CNT);
  assign do_pop  = kif.key_rd & ~empty;
  // a pop in the same cycle frees the slot, so a full FIFO still accepts
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf    <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (do_pop) ovf <= 1'b0;
      else if (push && full) ovf <= 1'b1;
    end
  end

  assign kif.key_data  = empty ? 8'h00 : mem[rd_ptr];
  assign kif.key_valid = ~empty;
  assign kif.key_count = count;
  assign kif.overflow  = ovf;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: directed scan-code
// sequences, expected ASCII queued and checked on each pop.
module tb_ps2_key_decoder;
  localparam int DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] scan_code = 8'h00;
  logic       scan_strobe = 1'b0;
  logic       drain_en = 1'b0;
  logic       mon_rd = 1'b0;
  logic       man_rd = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  ps2_key_if #(.DEPTH(DEPTH)) kif ();

  assign kif.key_rd = mon_rd | man_rd;

  ps2_key_decoder #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_code  (scan_code),
    .scan_strobe(scan_strobe),
    .kif        (kif)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // monitor: every accepted pop is compared against the queue head
  always @(negedge clk) begin
    logic [7:0] e;
    mon_rd = drain_en;
    if ((drain_en | man_rd) && kif.key_valid && !rst) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_unexpected act=%0h exp=none", kif.key_data);
      end else begin
        e = exp_q.pop_front();
        chk("pop_data", {24'h0, kif.key_data}, {24'h0, e});
      end
    end
  end

  task automatic send(input logic [7:0] b);
    @(posedge clk);
    #2 scan_code = b;
    scan_strobe = 1'b1;
    repeat (4) @(posedge clk);
    #2 scan_strobe = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic expect_key(input logic [7:0] b);
    exp_q.push_back(b);
  endtask

  task automatic set_drain(input logic v);
    @(posedge clk);
    #2 drain_en = v;
  endtask

  task automatic wait_empty(input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !kif.key_valid) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s act=%0d_left exp=0_left", name, exp_q.size());
    end
  endtask

  task automatic pulse_rst();
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_valid", kif.key_valid, 0);
    chk("rst_count", kif.key_count, 0);
    chk("rst_ovf", kif.overflow, 0);
    chk("rst_data", kif.key_data, 8'h00);

    // make + break of 'a'
    send(8'h1C); send(8'hF0); send(8'h1C);
    #1;
    chk("a_count", kif.key_count, 1);
    chk("a_data", kif.key_data, 8'h61);
    expect_key(8'h61);
    set_drain(1'b1);
    wait_empty("drain_a");

    // shift and caps
    expect_key(8'h41); expect_key(8'h61);
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    expect_key(8'h41); expect_key(8'h61);
    send(8'h58); send(8'h1C); send(8'h12); send(8'h1C);
    send(8'hF0); send(8'h12); send(8'h58); send(8'hF0); send(8'h58);

    // ctrl left and right
    expect_key(8'h03);
    send(8'h14); send(8'h21); send(8'hF0); send(8'h14);
    expect_key(8'h1A);
    send(8'hE0); send(8'h14); send(8'h1A);
    send(8'hE0); send(8'hF0); send(8'h14);

    // extended, unmapped, digits, others
    expect_key(8'h80);
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    send(8'h0E);
    expect_key(8'h31);
    send(8'h16);
    expect_key(8'h21); expect_key(8'h29);
    send(8'h12); send(8'h16); send(8'h45); send(8'hF0); send(8'h12);
    expect_key(8'h0D);
    send(8'h5A);
    expect_key(8'h81);
    send(8'hE0); send(8'hE0); send(8'h72);
    expect_key(8'h7A);
    send(8'h1A);
    wait_empty("drain_mixed");

    // latency: edge k high, entry visible after k+2
    set_drain(1'b0);
    @(posedge clk);
    #2 scan_code = 8'h29;
    scan_strobe = 1'b1;
    @(posedge clk); #1;
    chk("lat_k", kif.key_valid, 0);
    @(posedge clk); #1;
    chk("lat_k1", kif.key_valid, 0);
    @(posedge clk); #1;
    chk("lat_k2", kif.key_valid, 1);
    chk("lat_data", kif.key_data, 8'h20);
    #1 scan_strobe = 1'b0;
    repeat (4) @(posedge clk);
    expect_key(8'h20);
    set_drain(1'b1);
    wait_empty("drain_lat");
    set_drain(1'b0);

    // overflow
    for (int i = 0; i < DEPTH + 1; i++) begin
      if (i < DEPTH) expect_key(8'h20);
      send(8'h29);
    end
    #1;
    chk("ovf_count", kif.key_count, DEPTH);
    chk("ovf_flag", kif.overflow, 1);
    @(posedge clk);
    #2 man_rd = 1'b1;
    @(posedge clk);
    #1;
    chk("ovf_clr", kif.overflow, 0);
    chk("pop_count", kif.key_count, DEPTH - 1);
    #1 man_rd = 1'b0;

    expect_key(8'h20);
    send(8'h29);
    #1;
    chk("refill_count", kif.key_count, DEPTH);

    // write and pop on the same edge while full
    expect_key(8'h61);
    @(posedge clk);
    #2 scan_code = 8'h1C;
    scan_strobe = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 man_rd = 1'b1;
    @(posedge clk);
    #1;
    chk("wp_count", kif.key_count, DEPTH);
    chk("wp_ovf", kif.overflow, 0);
    #1 man_rd = 1'b0;
    repeat (3) @(posedge clk);
    #2 scan_strobe = 1'b0;
    repeat (4) @(posedge clk);
    set_drain(1'b1);
    wait_empty("drain_full");
    set_drain(1'b0);

    // fill then drain with key_rd held high
    for (int i = 0; i < DEPTH; i++) begin
      expect_key(i[0] ? 8'h62 : 8'h61);
      send(i[0] ? 8'h32 : 8'h1C);
    end
    #1;
    chk("fill_count", kif.key_count, DEPTH);
    chk("fill_ovf", kif.overflow, 0);
    @(posedge clk);
    #2 man_rd = 1'b1;
    repeat (DEPTH + 3) @(posedge clk);
    #1;
    chk("hold_valid", kif.key_valid, 0);
    chk("hold_count", kif.key_count, 0);
    chk("hold_left", exp_q.size(), 0);
    #1 man_rd = 1'b0;

    // strobe high across reset release
    set_drain(1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    scan_code = 8'h29;
    scan_strobe = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("strobe_rst_valid", kif.key_valid, 0);
    chk("strobe_rst_count", kif.key_count, 0);
    #1 scan_strobe = 1'b0;
    repeat (4) @(posedge clk);

    // reset discards a pending E0 prefix
    send(8'hE0);
    pulse_rst();
    send(8'h75);
    #1;
    chk("e0_rst_valid", kif.key_valid, 0);
    expect_key(8'h20);
    send(8'h29);
    wait_empty("drain_post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
